// File: rtl/input_conditioner_pkg.sv
// io_pkg: shared constants, sizing helper and repeat FSM state type for the input conditioner
package io_pkg;
  localparam int CLK_HZ = 50000000;
  localparam int DEBOUNCE_20MS = CLK_HZ / 50;
  localparam int REPEAT_500MS = CLK_HZ / 2;
  localparam int REPEAT_100MS = CLK_HZ / 10;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;
  function automatic int clog2(input int v);
    int r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/input_conditioner_if.sv
// input_conditioner_if: raw pin inputs and conditioned per-channel outputs
interface input_conditioner_if #(parameter int CHANNELS = 5);
  logic [CHANNELS-1:0] din, repeat_en, level, press, rel, busy;
  modport master (output din, repeat_en, input level, press, rel, busy);
  modport slave (input din, repeat_en, output level, press, rel, busy);
endinterface

// File: rtl/input_conditioner_channel.sv
// input_channel: synchroniser, counter debounce, edge pulses and auto-repeat for one pin
module input_channel
  import io_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int REPEAT_DELAY = REPEAT_500MS,
  parameter int REPEAT_RATE = REPEAT_100MS,
  parameter logic INV = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic rel,
  output logic busy
);
  localparam int CW = clog2(DEBOUNCE_CYCLES);
  localparam int RW = clog2(REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_MAX = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_MAX = RW'(REPEAT_RATE - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rc;
  rpt_state_t state, state_nx;
  logic s, done, rise, fall, held, rpt;
  assign s = sync[SYNC_STAGES-1] ^ INV;
  assign done = (s != level) && (cnt == CNT_MAX);
  assign rise = done & s;
  assign fall = done & ~s;
  // a release edge cancels any repeat pulse landing in the same cycle
  assign held = level & repeat_en & ~fall;
  assign busy = cnt != '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= {SYNC_STAGES{INV}};
      cnt <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      cnt <= (s == level || done) ? '0 : cnt + 1'b1;
      level <= done ? s : level;
      press <= rise | rpt;
      rel <= fall;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rc <= '0;
    end else begin
      state <= state_nx;
      rc <= (state == IDLE || rpt) ? '0 : rc + 1'b1;
    end
  always_comb
    state_nx = (state == IDLE) ? ((rise & repeat_en) ? DELAY : IDLE) :
               !held ? IDLE :
               (state == DELAY && rc == DELAY_MAX) ? REPEAT : state;
  always_comb
    rpt = held && ((state == DELAY && rc == DELAY_MAX) || (state == REPEAT && rc == RATE_MAX));
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: array of independent conditioned input channels
module input_conditioner
  import io_pkg::*;
#(
  parameter int CHANNELS = 5,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int REPEAT_DELAY = REPEAT_500MS,
  parameter int REPEAT_RATE = REPEAT_100MS,
  parameter logic [CHANNELS-1:0] INVERT = '0
) (
  input logic clk,
  input logic rst_n,
  input_conditioner_if.slave io
);
  logic [CHANNELS-1:0] level, press, rel, busy;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    input_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE(REPEAT_RATE),
      .INV(INVERT[i])
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .din(io.din[i]),
      .repeat_en(io.repeat_en[i]),
      .level(level[i]),
      .press(press[i]),
      .rel(rel[i]),
      .busy(busy[i])
    );
  end
  assign io.level = level;
  assign io.press = press;
  assign io.rel = rel;
  assign io.busy = busy;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: scoreboard bench for press/release/repeat timing of the input conditioner
module tb_input_conditioner;
  localparam int N = 3;
  localparam int PRESS = 0;
  localparam int REL = 1;
  typedef struct {int cyc; int ch; int kind;} ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  ev_t q[$];

  input_conditioner_if #(.CHANNELS(N)) bus ();
  input_conditioner #(
    .CHANNELS(N), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10), .REPEAT_RATE(3), .INVERT(3'b100)
  ) dut (.clk(clk), .rst_n(rst_n), .io(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expect_ev(input int c, input int ch, input int k);
    q.push_back('{c, ch, k});
  endfunction

  task automatic scoreboard();
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL missing_event: cyc %0d ch %0d kind %0d not seen by cyc %0d", q[0].cyc, q[0].ch, q[0].kind, cyc);
      void'(q.pop_front());
    end
    for (int ch = 0; ch < N; ch++)
      for (int k = 0; k < 2; k++)
        if ((k == PRESS) ? bus.press[ch] : bus.rel[ch]) begin
          n_chk++;
          if (q.size() > 0 && q[0].cyc == cyc && q[0].ch == ch && q[0].kind == k)
            void'(q.pop_front());
          else begin
            n_fail++;
            $display("FAIL unexpected_event: ch %0d kind %0d at cyc %0d, expected %0s", ch, k, cyc,
                     (q.size() > 0) ? $sformatf("cyc %0d ch %0d kind %0d", q[0].cyc, q[0].ch, q[0].kind) : "none");
          end
        end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      scoreboard();
    end
  endtask

  task automatic test_reset();
    int c;
    rst_n = 1'b0;
    bus.din = 3'b100;
    bus.repeat_en = 3'b000;
    tick(3);
    n_chk++;
    if ({bus.level, bus.press, bus.rel, bus.busy} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, want 0", {bus.level, bus.press, bus.rel, bus.busy});
    end
    rst_n = 1'b1;
    tick(50);
    n_chk++;
    if (bus.level !== 3'b000 || bus.busy !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: level %b busy %b, want 000 000", bus.level, bus.busy);
    end
    c = cyc;
    bus.din[2] = 1'b0;
    expect_ev(c + 6, 2, PRESS);
    tick(3);
    n_chk++;
    if (bus.busy[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_inverted: busy[2] %b, want 1", bus.busy[2]);
    end
    tick(2);
    n_chk++;
    if (bus.level[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL level_early: level[2] %b at edge 5, want 0", bus.level[2]);
    end
    tick(2);
    n_chk++;
    if (bus.level[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL level_inverted: level[2] %b, want 1", bus.level[2]);
    end
    bus.din[2] = 1'b1;
    expect_ev(cyc + 6, 2, REL);
    tick(8);
  endtask

  task automatic test_press_release();
    bus.din[0] = 1'b1;
    expect_ev(cyc + 6, 0, PRESS);
    tick(7);
    n_chk++;
    if (bus.level[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL level_press: level[0] %b, want 1", bus.level[0]);
    end
    bus.din[0] = 1'b0;
    expect_ev(cyc + 6, 0, REL);
    tick(7);
    n_chk++;
    if (bus.level[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL level_release: level[0] %b, want 0", bus.level[0]);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 4; i++) begin
      bus.din[0] = (i % 2 == 0);
      tick(2);
    end
    n_chk++;
    if (bus.level[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_level: level[0] %b after bounce, want 0", bus.level[0]);
    end
    bus.din[0] = 1'b1;
    expect_ev(cyc + 6, 0, PRESS);
    tick(4);
    n_chk++;
    if (bus.busy[0] !== 1'b1 || bus.level[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_busy: busy[0] %b level[0] %b, want 1 0", bus.busy[0], bus.level[0]);
    end
    tick(2);
    n_chk++;
    if (bus.busy[0] !== 1'b0 || bus.level[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_settle: busy[0] %b level[0] %b, want 0 1", bus.busy[0], bus.level[0]);
    end
    bus.din[0] = 1'b0;
    expect_ev(cyc + 6, 0, REL);
    tick(8);
  endtask

  task automatic test_repeat();
    int c;
    c = cyc;
    bus.repeat_en = 3'b010;
    bus.din[1] = 1'b1;
    expect_ev(c + 6, 1, PRESS);
    // the eleventh repeat would fall on c+46, which is the release cycle
    for (int k = 0; k < 10; k++) expect_ev(c + 16 + 3 * k, 1, PRESS);
    expect_ev(c + 46, 1, REL);
    tick(40);
    n_chk++;
    if (bus.level[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL repeat_level: level[1] %b, want 1", bus.level[1]);
    end
    bus.din[1] = 1'b0;
    tick(8);
  endtask

  task automatic test_repeat_enable();
    int d;
    bus.repeat_en = 3'b010;
    bus.din[1] = 1'b1;
    expect_ev(cyc + 6, 1, PRESS);
    tick(8);
    bus.repeat_en = 3'b000;
    tick(12);
    bus.repeat_en = 3'b010;
    tick(20);
    bus.din[1] = 1'b0;
    expect_ev(cyc + 6, 1, REL);
    tick(8);
    d = cyc;
    bus.din[1] = 1'b1;
    expect_ev(d + 6, 1, PRESS);
    expect_ev(d + 16, 1, PRESS);
    expect_ev(d + 19, 1, PRESS);
    expect_ev(d + 22, 1, PRESS);
    expect_ev(d + 23, 1, REL);
    tick(17);
    bus.din[1] = 1'b0;
    tick(8);
    bus.repeat_en = 3'b000;
  endtask

  task automatic test_reset_mid();
    int r;
    bus.din = 3'b011;
    tick(4);
    n_chk++;
    if (bus.busy !== 3'b111) begin
      n_fail++;
      $display("FAIL mid_busy: busy %b, want 111", bus.busy);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.level, bus.press, bus.rel, bus.busy} !== 12'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h, want 0", {bus.level, bus.press, bus.rel, bus.busy});
    end
    tick(2);
    rst_n = 1'b1;
    r = cyc;
    for (int ch = 0; ch < N; ch++) expect_ev(r + 6, ch, PRESS);
    tick(5);
    n_chk++;
    if (bus.level !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_level_early: level %b, want 000", bus.level);
    end
    tick(2);
    n_chk++;
    if (bus.level !== 3'b111) begin
      n_fail++;
      $display("FAIL simultaneous_level: level %b, want 111", bus.level);
    end
    bus.din = 3'b100;
    for (int ch = 0; ch < N; ch++) expect_ev(cyc + 6, ch, REL);
    tick(8);
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_repeat();
    test_repeat_enable();
    test_reset_mid();
    tick(4);
    n_chk++;
    if (q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d events left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Parametrised, multi-channel successor to the single-switch debouncer that feeds the computer's reset and button inputs.
- Per channel: synchroniser, counter-based debounce, press/release edge pulses, optional auto-repeat.
- Sits between board pins (SW, KEY) and the CPU / top-level logic. One instance conditions the reset switch, the sample key and the three CPU buttons.

Parameters:
- CHANNELS, 5, number of independent input channels (1..32).
- SYNC_STAGES, 2, synchroniser flop depth (2..4).
- DEBOUNCE_CYCLES, 1000000, clock cycles an input must differ from Level continuously before Level toggles. Default is 20 ms at 50 MHz. Must be >= 2.
- REPEAT_DELAY, 25000000, cycles from a press until the first auto-repeat pulse. Must be >= 2.
- REPEAT_RATE, 5000000, cycles between subsequent auto-repeat pulses. Must be >= 2.
- INVERT, all zeros, CHANNELS-bit mask. A 1 marks an active-low pin (KEY), inverted after synchronisation.

Ports:
- Clock  in  1  system clock (50 MHz).
- Reset  in  1  asynchronous, active-low reset.
- Din  in  CHANNELS  raw, asynchronous pin levels.
- RepeatEn  in  CHANNELS  per-channel auto-repeat enable, synchronous to Clock.
- Level  out  CHANNELS  debounced level, 1 = pressed/on after INVERT.
- Press  out  CHANNELS  one-cycle pulse on debounced rising edge and on each auto-repeat.
- Release  out  CHANNELS  one-cycle pulse on debounced falling edge.
- Busy  out  CHANNELS  1 while the channel's debounce counter is non-zero.

Behaviour:
- Reset (Reset=0, asynchronous): all outputs 0, all counters 0.
  - Synchroniser flops reset to the released value (Din=INVERT bit), so a held-inactive pin gives no event after reset release.
- Synchroniser: s = last sync stage XOR INVERT[i]. s lags Din by SYNC_STAGES cycles.
- Debounce counter cnt, width clog2(DEBOUNCE_CYCLES):
  - s == Level: cnt <= 0.
  - s != Level and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s != Level and cnt == DEBOUNCE_CYCLES-1: Level <= s, cnt <= 0.
- Latency: Level changes exactly SYNC_STAGES + DEBOUNCE_CYCLES edges after a clean Din transition. Any glitch back to Level restarts the count from 0.
- Press/Release are registered and asserted in the same cycle the new Level first appears. They are never both high on one channel.
- Auto-repeat, per-channel FSM with states IDLE, DELAY, REPEAT:
  - IDLE -> DELAY on debounced press; repeat counter rc <= 0.
  - DELAY: rc increments each cycle. At rc == REPEAT_DELAY-1: Press pulse, rc <= 0, go to REPEAT.
  - REPEAT: at rc == REPEAT_RATE-1: Press pulse, rc <= 0.
  - Any state -> IDLE immediately when Level is 0 or RepeatEn[i] is 0. No repeat pulse in the release cycle.
  - RepeatEn sampled every cycle. Re-enabling while held starts no repeat until the next debounced press.
- Simultaneous events: channels are fully independent. Any combination of pulses in one cycle is legal.
- Reset mid-debounce or mid-repeat: counters clear, Level 0, FSM IDLE. A pin still held after reset release produces a fresh Press after full latency.
- Counter wrap: rc and cnt saturate by construction; no wrap-around is reachable.
- Busy = (cnt != 0).

Decomposition:
- Shared package io_pkg:
  - clog2 function.
  - CLK_HZ = 50000000.
  - Derived constants DEBOUNCE_20MS, REPEAT_500MS, REPEAT_100MS.
  - Repeat FSM state enum {IDLE, DELAY, REPEAT}.
- Sub-module input_channel: one synchroniser + debounce + edge + repeat FSM. Top level is a generate loop over CHANNELS plus INVERT bit selection.

Test Plan (CHANNELS=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, INVERT=3'b100 unless noted):
- Reset release with Din=3'b100 held -> Level=0, Press=0, Release=0 for 50 cycles. Then drive Din[2]=0 -> Level[2]=1 and Press[2]=1 exactly 6 cycles after the drive edge.
- Din[0] 0->1 held -> Level[0]=1 and one-cycle Press[0] at edge 6. Then Din[0] 1->0 -> Release[0] one cycle at edge 6 after the drop.
- Din[0] bounce 1,0,1,0 at 2-cycle spacing, then stable 1 -> no Level change during bounce. Press[0] 6 cycles after the final stable edge. Busy[0] high during the count.
- RepeatEn[1]=1, Din[1] held 1 for 40 cycles -> Press[1] at press cycle P, then P+10, P+13, P+16, ... No Press in the Release cycle.
- RepeatEn[1] dropped while held -> no further Press[1]. Raising it again while still held -> no repeat until release and re-press.
- Reset asserted mid-count (cnt=2) on ch0 with Din[0]=1 held -> outputs 0 immediately. After release, Press[0] 6 cycles later. Repeat with all three channels toggling on the same edge -> three simultaneous Press pulses.
